// File: rtl/flux_capture_ctrl.sv
// Sequences one flux-capture pass: arm, wait for INDEX, capture N revolutions of edge/index words.
// Optional FLUX_CAPTURE_STATS_EN adds edge_count and drop_count statistics ports.
module flux_capture_ctrl #(
    parameter int unsigned IDX_TIMEOUT = 200000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [3:0]  rev_count,
    input  logic        index_in,
    input  logic        edge_detected,
    input  logic        edge_polarity,
    input  logic [15:0] edge_interval,
    input  logic        fifo_full,
    output logic        det_enable,
    output logic        wr_valid,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  revs_done,
    output logic        timeout_err,
    output logic        overflow,
`ifdef FLUX_CAPTURE_STATS_EN
    output logic        aborted,
    output logic [31:0] edge_count,
    output logic [15:0] drop_count
`else
    output logic        aborted
`endif
);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t      state, state_nxt;
    logic        idx_s1, idx_s2, idx_prev;
    logic        idx_rise;
    logic [31:0] to_cnt;
    logic        timeout_hit;
    logic [3:0]  rev_latched;
    logic [3:0]  revs_inc;
    logic        last_rev;
    logic        capture_word;
    logic        pend_vld;
    logic [31:0] pend_dat;

    assign idx_rise     = idx_s2 & ~idx_prev;
    assign timeout_hit  = (to_cnt == 32'(IDX_TIMEOUT - 1));
    assign revs_inc     = (revs_done == 4'hF) ? 4'hF : revs_done + 4'd1;
    assign last_rev     = idx_rise && (revs_inc == rev_latched);
    assign capture_word = (state == CAPTURE) && !cmd_abort && (edge_detected || idx_rise);

    assign det_enable = (state == CAPTURE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    // The pending word is dropped, not delayed, when the FIFO is full in its write cycle.
    assign wr_valid   = pend_vld & ~fifo_full;
    assign wr_data    = pend_dat;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_start) state_nxt = ARM;
            ARM: begin
                if (cmd_abort)        state_nxt = DONE;
                else if (idx_rise)    state_nxt = CAPTURE;
                else if (timeout_hit) state_nxt = DONE;
            end
            CAPTURE: begin
                if (cmd_abort)                     state_nxt = DONE;
                else if (last_rev)                 state_nxt = DONE;
                else if (!idx_rise && timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_s1      <= 1'b0;
            idx_s2      <= 1'b0;
            idx_prev    <= 1'b0;
            to_cnt      <= '0;
            rev_latched <= '0;
            revs_done   <= '0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
            aborted     <= 1'b0;
            pend_vld    <= 1'b0;
            pend_dat    <= '0;
`ifdef FLUX_CAPTURE_STATS_EN
            edge_count  <= '0;
            drop_count  <= '0;
`endif
        end else begin
            idx_s1   <= index_in;
            idx_s2   <= idx_s1;
            idx_prev <= idx_s2;

            pend_vld <= capture_word;
            if (capture_word)
                pend_dat <= {idx_rise, edge_detected, edge_detected & edge_polarity, 13'd0,
                             edge_detected ? edge_interval : 16'd0};

            if (pend_vld && fifo_full) begin
                overflow <= 1'b1;
`ifdef FLUX_CAPTURE_STATS_EN
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
            end

            case (state)
                IDLE: if (cmd_start) begin
                    rev_latched <= (rev_count == 4'd0) ? 4'd1 : rev_count;
                    revs_done   <= '0;
                    timeout_err <= 1'b0;
                    overflow    <= 1'b0;
                    aborted     <= 1'b0;
                    to_cnt      <= '0;
`ifdef FLUX_CAPTURE_STATS_EN
                    edge_count  <= '0;
                    drop_count  <= '0;
`endif
                end
                ARM: begin
                    if (cmd_abort)        aborted     <= 1'b1;
                    else if (idx_rise)    to_cnt      <= '0;
                    else if (timeout_hit) timeout_err <= 1'b1;
                    else                  to_cnt      <= to_cnt + 32'd1;
                end
                CAPTURE: begin
                    if (cmd_abort) begin
                        aborted <= 1'b1;
                    end else begin
                        if (idx_rise) begin
                            to_cnt    <= '0;
                            revs_done <= revs_inc;
                        end else if (timeout_hit) begin
                            timeout_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 32'd1;
                        end
`ifdef FLUX_CAPTURE_STATS_EN
                        if (edge_detected && edge_count != 32'hFFFF_FFFF)
                            edge_count <= edge_count + 32'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flux_capture_ctrl.sv
// Directed bench for flux_capture_ctrl with hand-computed capture words and flag expectations.
module tb_flux_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [3:0]  rev_count = 4'd0;
    logic        index_in = 1'b0;
    logic        edge_detected = 1'b0;
    logic        edge_polarity = 1'b0;
    logic [15:0] edge_interval = 16'd0;
    logic        fifo_full = 1'b0;
    logic        det_enable, wr_valid, busy, done;
    logic        timeout_err, overflow, aborted;
    logic [31:0] wr_data;
    logic [3:0]  revs_done;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int det_cnt = 0;
    int last_done_cyc = 0;
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    flux_capture_ctrl #(.IDX_TIMEOUT(1000)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .rev_count(rev_count), .index_in(index_in), .edge_detected(edge_detected),
        .edge_polarity(edge_polarity), .edge_interval(edge_interval), .fifo_full(fifo_full),
        .det_enable(det_enable), .wr_valid(wr_valid), .wr_data(wr_data), .busy(busy),
        .done(done), .revs_done(revs_done), .timeout_err(timeout_err),
        .overflow(overflow), .aborted(aborted)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_valid) wq.push_back(wr_data);
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (det_enable) det_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wget(input int i);
        return (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [3:0] rc);
        cmd_start = 1'b1;
        rev_count = rc;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic idx_pulse();
        index_in = 1'b1;
        step(3);
        index_in = 1'b0;
        step(4);
    endtask

    task automatic edge_ev(input logic pol, input logic [15:0] iv);
        edge_detected = 1'b1;
        edge_polarity = pol;
        edge_interval = iv;
        step();
        edge_detected = 1'b0;
        step(2);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int base, d0, det0, t0, dly;
        logic [31:0] exp1 [6];
        exp1 = '{32'h6000_0064, 32'h6000_00C8, 32'h6000_012C,
                 32'h8000_0000, 32'h6000_0032, 32'h8000_0000};

        step(3);
        check("rst_busy", busy, 0);
        check("rst_flags", {timeout_err, overflow, aborted, done, det_enable, wr_valid}, 0);
        check("rst_data", wr_data, 0);
        check("rst_revs", revs_done, 0);
        reset = 1'b0;
        step();

        // Two-revolution capture
        base = wq.size();
        d0 = done_cnt;
        start(4'd2);
        check("t1_busy", busy, 1);
        check("t1_arm_det", det_enable, 0);
        idx_pulse();
        check("t1_cap_det", det_enable, 1);
        check("t1_no_arm_word", wq.size() - base, 0);
        edge_ev(1'b1, 16'd100);
        edge_ev(1'b1, 16'd200);
        edge_ev(1'b1, 16'd300);
        idx_pulse();
        edge_ev(1'b1, 16'd50);
        idx_pulse();
        wait_idle("t1_idle", 20);
        check("t1_nwords", wq.size() - base, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_word%0d", i), wget(base + i), exp1[i]);
        check("t1_done", done_cnt - d0, 1);
        check("t1_revs", revs_done, 2);
        check("t1_det_off", det_enable, 0);

        // Edge coincident with index, then abort with a coincident edge
        start(4'd3);
        idx_pulse();
        base = wq.size();
        index_in = 1'b1;
        step(2);
        edge_detected = 1'b1;
        edge_polarity = 1'b1;
        edge_interval = 16'h1234;
        step();
        edge_detected = 1'b0;
        step();
        index_in = 1'b0;
        step(4);
        check("t2_nwords", wq.size() - base, 1);
        check("t2_word", wget(base), 32'hE000_1234);
        check("t2_revs", revs_done, 1);
        base = wq.size();
        d0 = done_cnt;
        cmd_abort = 1'b1;
        edge_detected = 1'b1;
        edge_interval = 16'h0005;
        step();
        cmd_abort = 1'b0;
        edge_detected = 1'b0;
        check("ab_done", done, 1);
        check("ab_flag", aborted, 1);
        check("ab_busy1", busy, 1);
        step();
        check("ab_busy0", busy, 0);
        check("ab_done_end", done, 0);
        step(3);
        check("ab_nwords", wq.size() - base, 0);
        check("ab_done_cnt", done_cnt - d0, 1);

        // FIFO full drops two edge words
        base = wq.size();
        start(4'd2);
        check("ov_clr", {overflow, aborted}, 0);
        idx_pulse();
        fifo_full = 1'b1;
        edge_ev(1'b0, 16'h0011);
        edge_ev(1'b1, 16'h0022);
        step(2);
        fifo_full = 1'b0;
        check("ov_flag", overflow, 1);
        check("ov_dropped", wq.size() - base, 0);
        edge_ev(1'b0, 16'h0033);
        idx_pulse();
        idx_pulse();
        wait_idle("ov_idle", 20);
        check("ov_nwords", wq.size() - base, 3);
        check("ov_word", wget(base), 32'h4000_0033);
        check("ov_sticky", overflow, 1);

        // Index timeout from ARM
        base = wq.size();
        d0 = done_cnt;
        det0 = det_cnt;
        cmd_start = 1'b1;
        rev_count = 4'd1;
        step();
        t0 = cyc;
        cmd_start = 1'b0;
        wait_idle("to_idle", 1200);
        dly = last_done_cyc - t0;
        check("to_done", done_cnt - d0, 1);
        check("to_flag", timeout_err, 1);
        check("to_delay", (dly >= 999 && dly <= 1001), 1);
        check("to_nwords", wq.size() - base, 0);
        check("to_det", det_cnt - det0, 0);

        // rev_count=0 means one revolution; restart while busy is ignored
        base = wq.size();
        d0 = done_cnt;
        start(4'd0);
        check("r0_to_clr", timeout_err, 0);
        idx_pulse();
        cmd_start = 1'b1;
        rev_count = 4'd5;
        step();
        cmd_start = 1'b0;
        check("r0_busy", busy, 1);
        idx_pulse();
        wait_idle("r0_idle", 20);
        check("r0_revs", revs_done, 1);
        check("r0_done", done_cnt - d0, 1);
        check("r0_nwords", wq.size() - base, 1);
        check("r0_word", wget(base), 32'h8000_0000);

        // Reset mid-capture
        start(4'd3);
        idx_pulse();
        d0 = done_cnt;
        reset = 1'b1;
        step();
        check("mr_state", {busy, det_enable, revs_done}, 0);
        reset = 1'b0;
        step(3);
        check("mr_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
